// File: rtl/sat_accum_unit.sv
// sat_accum_unit
//   Saturating accumulator stage. Sums a run of LEN operands received over a
//   valid/ready stream, clamping each partial sum on overflow (signed or
//   unsigned, chosen per run). Returns the sum with per-run clamp flags and a
//   sticky clamp flag for the execute/writeback side of the core.
//
// Build option
//   SAT_ACCUM_PIPE_EN : register accepted operands in an operand stage and add
//                       them one cycle later. Result appears one cycle later;
//                       throughput stays at one beat per cycle.
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   start          begin a run (sampled only when idle)
//   len            beats in the run, latched on start
//   signed_mode    1 = two's-complement clamping, 0 = unsigned; latched on start
//   in_valid/in_ready/in_data     operand stream
//   out_valid/out_ready/out_data  result handshake and saturated sum
//   out_sat_p      some add in this run clamped to positive max
//   out_sat_n      some add in this run clamped to negative max (signed only)
//   busy           a run is in progress or its result is pending
//   sat_sticky     any clamp since last sat_clr/reset
//   sat_clr        clear sat_sticky (a same-cycle clamp wins)

module sat_accum_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             signed_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat_p,
    output logic             out_sat_n,
    output logic             busy,
    output logic             sat_sticky,
    input  logic             sat_clr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             signed_q;
    logic [WIDTH-1:0] acc;
    logic             sat_p_q;
    logic             sat_n_q;
    logic             sticky_q;

    logic             accept;
    logic             add_en;
    logic [WIDTH-1:0] add_data;
    logic             last_add;
    logic [WIDTH+1:0] add_res;   // {clamp_pos, clamp_neg, sum}
    logic [WIDTH-1:0] add_sum;
    logic             add_p;
    logic             add_n;

    // Saturating add. Returns {clamp_pos, clamp_neg, result}.
    function automatic logic [WIDTH+1:0] sat_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sm
    );
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] res;
        logic             p;
        logic             n;
        full = {1'b0, a} + {1'b0, b};
        res  = full[WIDTH-1:0];
        p    = 1'b0;
        n    = 1'b0;
        if (sm) begin
            if (!a[WIDTH-1] && !b[WIDTH-1] && full[WIDTH-1]) begin
                res = {1'b0, {(WIDTH-1){1'b1}}};
                p   = 1'b1;
            end else if (a[WIDTH-1] && b[WIDTH-1] && !full[WIDTH-1]) begin
                res = {1'b1, {(WIDTH-1){1'b0}}};
                n   = 1'b1;
            end
        end else if (full[WIDTH]) begin
            res = '1;
            p   = 1'b1;
        end
        return {p, n, res};
    endfunction

    assign count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
    // count tracks accepted beats, so ready drops as soon as the last one is taken
    assign in_ready  = (state == S_ACCUM) && (count != len_q);
    assign accept    = in_valid && in_ready;

`ifdef SAT_ACCUM_PIPE_EN
    logic             op_valid;
    logic [WIDTH-1:0] op_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_data  <= '0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                op_data <= in_data;
            end
        end
    end

    assign add_en   = op_valid;
    assign add_data = op_data;
    // The staged operand is the last one once every beat has been accepted.
    assign last_add = op_valid && (count == len_q);
`else
    assign add_en   = accept;
    assign add_data = in_data;
    assign last_add = accept && (count_nxt == len_q);
`endif

    assign add_res = sat_add(acc, add_data, signed_q);
    assign add_p   = add_res[WIDTH+1];
    assign add_n   = add_res[WIDTH];
    assign add_sum = add_res[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            count    <= '0;
            signed_q <= 1'b0;
            acc      <= '0;
            sat_p_q  <= 1'b0;
            sat_n_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            // A clamp in this cycle overrides a simultaneous clear.
            if (add_en && (add_p || add_n)) begin
                sticky_q <= 1'b1;
            end else if (sat_clr) begin
                sticky_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        signed_q <= signed_mode;
                        acc      <= '0;
                        count    <= '0;
                        sat_p_q  <= 1'b0;
                        sat_n_q  <= 1'b0;
                        state    <= (len == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        count <= count_nxt;
                    end
                    if (add_en) begin
                        acc <= add_sum;
                        if (add_p) sat_p_q <= 1'b1;
                        if (add_n) sat_n_q <= 1'b1;
                    end
                    if (last_add) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = (state == S_DONE);
    assign out_data   = acc;
    assign out_sat_p  = sat_p_q;
    assign out_sat_n  = sat_n_q;
    assign busy       = (state != S_IDLE);
    assign sat_sticky = sticky_q;

endmodule
